// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Operands are latched at start; the result is committed when the busy count expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic [63:0] prod;
    logic        sdiv;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    // Result datapath from the latched operands; divides work on magnitudes
    // so the 0x80000000 / -1 case wraps to 0x80000000 without overflow.
    always_comb begin
        prod   = 64'd0;
        sdiv   = (op == OP_DIV);
        mag_a  = op_a;
        mag_b  = op_b;
        uq     = 32'd0;
        ur     = 32'd0;
        quot   = 32'd0;
        rem    = 32'd0;
        res_hi = hi;
        res_lo = lo;
        res_we = 1'b0;
        if (op == OP_MULT) begin
            prod = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        end else begin
            prod = {32'd0, op_a} * {32'd0, op_b};
        end
        if (sdiv && op_a[31]) begin
            mag_a = 32'd0 - op_a;
        end
        if (sdiv && op_b[31]) begin
            mag_b = 32'd0 - op_b;
        end
        if (op_b != 32'd0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        quot = (sdiv && (op_a[31] ^ op_b[31])) ? 32'd0 - uq : uq;
        rem  = (sdiv && op_a[31]) ? 32'd0 - ur : ur;
        case (op)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quot;
                res_we = (op_b != 32'd0);
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // Control FSM with registered busy and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= 4'd0;
            op    <= 3'd0;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (mdop)
                            OP_MULT, OP_MULTU: begin
                                op    <= mdop;
                                op_a  <= A;
                                op_b  <= B;
                                count <= 4'(MULT_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op    <= mdop;
                                op_a  <= A;
                                op_b  <= B;
                                count <= 4'(DIV_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide execution unit in the E stage, beside the single-cycle ALU.
- Accepts one operation per start pulse and holds busy for a fixed latency. It then commits results to the architectural HI/LO registers, which it owns.
- Covers mult/multu/div/divu/mthi/mtlo. The hazard unit stalls mfhi/mflo and any new md instruction while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse; qualifies mdop.
- mdop  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- B  input  32  operand rt (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  HI register value.
- lo  output  32  LO register value.

Behaviour:
- Reset (synchronous, sampled at rising clk while reset=1):
  - busy=0, hi=0, lo=0, counter=0, FSM=IDLE.
  - Reset overrides start in the same cycle and aborts any in-flight operation; HI/LO do not take the pending result.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1; counter decrements each cycle.
- Starting an operation: at an edge in IDLE with start=1 and mdop in {1..4}:
  - Latch A, B and mdop into internal operand registers.
  - Load counter with MULT_CYCLES (mdop 1,2) or DIV_CYCLES (mdop 3,4).
  - Go to RUN.
  - busy is first high in the cycle after start.
- RUN to IDLE: at the edge where counter==1:
  - Write hi/lo with the result and go to IDLE.
  - busy is high for exactly N cycles. New hi/lo are visible in the first cycle busy=0.
  - Total latency from start to valid hi/lo is N+1 cycles.
- mthi / mtlo: start=1 with mdop 5 in IDLE sets hi<=A; mdop 6 sets lo<=A. This takes one edge, busy stays 0, and the other register is unchanged.
- Ignored requests (no state change):
  - start=1 while busy=1 (the pipeline guarantees this never happens; the block is still robust to it).
  - mdop 0 or 7.
  - Operand changes on A/B after the start edge (operands are latched).
- Arithmetic, using the latched operands:
  - mult: {hi,lo} = signed(A) * signed(B), full 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - div with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - divu: lo = A/B, hi = A%B, both unsigned.
  - Divide by zero (B==0, div or divu): busy sequence runs normally and hi/lo retain their prior values at completion.
- Implementation freedom: iterative or one-shot datapath computed at the start edge. The externally visible timing above is mandatory.
- hi and lo are registered outputs and never glitch between commits.

Test Plan:
- Reset, then mult A=0xFFFFFFFE (-2), B=3 → busy high cycles 1..5; at cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001. Changing A/B during busy does not affect the result.
- div A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then divu A=7, B=2 → lo=3, hi=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on the next cycle → busy never asserts; hi=0x12345678, lo=0x9ABCDEF0. Then div with B=0 → busy 10 cycles and hi/lo unchanged.
- Overflow and ignored start: div A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0. A second start (mult 2*2) pulsed in busy cycle 3 is ignored: busy falls after 10 cycles and no extra busy period follows.
- Mid-operation reset: start mult A=4, B=5 after mthi sets hi=0xAAAA0000, assert reset in busy cycle 2 → next cycle busy=0, hi=0, lo=0, and no later commit of 20.
